// File: rtl/alu_muldiv.sv
// alu_muldiv: registered single-cycle ALU plus iterative multiply/divide
// into Hi/Lo, with a start/busy/done handshake for controller stalls.
module alu_muldiv #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   alucontrol,
    input  logic         sign,
    output logic [N-1:0] result,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         zero,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t           state_q;
    logic [N-1:0]     result_q, hi_q, lo_q, d_q;
    logic [2*N-1:0]   p_q;
    logic [SHW-1:0]   cnt_q;
    logic             busy_q, done_q, dbz_q, dbz_pend_q;
    logic             is_div_q, neg_q, neg_r_q;

    logic [N-1:0]     abs_a, abs_b, alu_d, fin_hi_d, fin_lo_d;
    logic [N-1:0]     mul_d_in, div_d_in, quo, rem;
    logic [2*N-1:0]   mul_p_in, div_p_in, mul_step_d, div_step_d, prod;
    logic [N:0]       msum, shifted, diff;
    logic             ge;

    // Single-cycle ALU result from the live operands (sampled on accept)
    always_comb begin
        alu_d = '0;
        case (alucontrol)
            4'b0000: alu_d = a + b;
            4'b0001: alu_d = a - b;
            4'b0100: alu_d = a & b;
            4'b0101: alu_d = a | b;
            4'b0110: alu_d = ~a;
            4'b0111: alu_d = a << b[SHW-1:0];
            4'b1000: alu_d = sign ? N'($signed(a) >>> b[SHW-1:0]) : (a >> b[SHW-1:0]);
            4'b1001: alu_d = sign ? N'($signed(a) < $signed(b)) : N'(a < b);
            4'b1010: alu_d = hi_q;
            4'b1011: alu_d = lo_q;
            default: alu_d = '0;
        endcase
    end

    // One shift-add / restoring-divide step; in IDLE the step is fed from the
    // live operands so the accept edge already performs the first iteration.
    always_comb begin
        abs_a    = (sign && a[N-1]) ? -a : a;
        abs_b    = (sign && b[N-1]) ? -b : b;
        mul_p_in = (state_q == IDLE) ? {{N{1'b0}}, abs_b} : p_q;
        mul_d_in = (state_q == IDLE) ? abs_a : d_q;
        div_p_in = (state_q == IDLE) ? {{N{1'b0}}, abs_a} : p_q;
        div_d_in = (state_q == IDLE) ? abs_b : d_q;

        msum       = {1'b0, mul_p_in[2*N-1:N]} + (mul_p_in[0] ? {1'b0, mul_d_in} : '0);
        mul_step_d = {msum, mul_p_in[N-1:1]};

        shifted    = {div_p_in[2*N-1:N], div_p_in[N-1]};
        diff       = shifted - {1'b0, div_d_in};
        ge         = ~diff[N];
        div_step_d = {(ge ? diff[N-1:0] : shifted[N-1:0]), div_p_in[N-2:0], ge};
    end

    // Sign correction and Hi/Lo selection applied in FIN
    always_comb begin
        prod = neg_q ? -p_q : p_q;
        quo  = neg_q ? -p_q[N-1:0] : p_q[N-1:0];
        rem  = neg_r_q ? -p_q[2*N-1:N] : p_q[2*N-1:N];
        if (dbz_pend_q) begin
            fin_hi_d = p_q[2*N-1:N];
            fin_lo_d = p_q[N-1:0];
        end else if (is_div_q) begin
            fin_hi_d = rem;
            fin_lo_d = quo;
        end else begin
            fin_hi_d = prod[2*N-1:N];
            fin_lo_d = prod[N-1:0];
        end
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            result_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            p_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_r_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dbz_q <= 1'b0;
                        case (alucontrol)
                            4'b0010: begin
                                state_q    <= MUL;
                                busy_q     <= 1'b1;
                                is_div_q   <= 1'b0;
                                dbz_pend_q <= 1'b0;
                                neg_q      <= sign & (a[N-1] ^ b[N-1]);
                                neg_r_q    <= 1'b0;
                                p_q        <= mul_step_d;
                                d_q        <= abs_a;
                                cnt_q      <= SHW'(N-2);
                            end
                            4'b0011: begin
                                busy_q   <= 1'b1;
                                is_div_q <= 1'b1;
                                if (b == '0) begin
                                    state_q    <= FIN;
                                    dbz_pend_q <= 1'b1;
                                    neg_q      <= 1'b0;
                                    neg_r_q    <= 1'b0;
                                    p_q        <= {a, {N{1'b1}}};
                                end else begin
                                    state_q    <= DIV;
                                    dbz_pend_q <= 1'b0;
                                    neg_q      <= sign & (a[N-1] ^ b[N-1]);
                                    neg_r_q    <= sign & a[N-1];
                                    p_q        <= div_step_d;
                                    d_q        <= abs_b;
                                    cnt_q      <= SHW'(N-2);
                                end
                            end
                            default: begin
                                result_q <= alu_d;
                                done_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    p_q   <= mul_step_d;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == '0) state_q <= FIN;
                end
                DIV: begin
                    p_q   <= div_step_d;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == '0) state_q <= FIN;
                end
                FIN: begin
                    hi_q     <= fin_hi_d;
                    lo_q     <= fin_lo_d;
                    result_q <= fin_lo_d;
                    dbz_q    <= dbz_pend_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result      = result_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign zero        = (result_q == '0);
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (N=32).
module tb_alu_muldiv;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a, b;
    logic [3:0]   alucontrol;
    logic         sign;
    logic [N-1:0] result, hi, lo;
    logic         zero, busy, done, div_by_zero;

    int pass_cnt = 0;
    int total_cnt = 0;
    int lat;
    int ndone;

    alu_muldiv #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .alucontrol(alucontrol), .sign(sign), .result(result), .hi(hi),
        .lo(lo), .zero(zero), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one op; returns edges from the accept edge (1) to the done edge.
    // poke>0 raises a competing start at that count while the op iterates.
    task automatic run_op(input logic [3:0] op, input logic s, input logic [N-1:0] aa,
                          input logic [N-1:0] bb, input int poke, output int l);
        @(negedge clk);
        alucontrol = op; sign = s; a = aa; b = bb; start = 1'b1;
        l = 0;
        do begin
            @(posedge clk); #1;
            l++;
            if (l == 1) start = 1'b0;
            if (poke > 0 && l == poke) begin
                check("busy_mid", busy, 1);
                start = 1'b1; alucontrol = 4'b0000; a = 1; b = 1;
            end
            if (poke > 0 && l == poke + 1) start = 1'b0;
        end while (!done && l < 100);
        if (!done) check("timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; a = 5; b = 3; alucontrol = 4'b0000; sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_hilo", {hi, lo}, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("add_after_rst", result, 8);
        check("add_done", done, 1);
        start = 1'b0;

        // signed multiply with an ignored start while busy
        run_op(4'b0010, 1'b1, -32'sd3, 32'd7, 5, lat);
        check("mul_lat", lat, 33);
        check("mul_hi", hi, 32'hFFFFFFFF);
        check("mul_lo", lo, 32'hFFFFFFEB);
        check("mul_res", result, 32'hFFFFFFEB);
        check("mul_busy_end", busy, 0);
        @(posedge clk); #1;
        check("mul_no_extra_done", done, 0);
        check("mul_res_hold", result, 32'hFFFFFFEB);

        // unsigned multiply boundary
        run_op(4'b0010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat);
        check("mulu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        // unsigned divide, then read hi/lo
        run_op(4'b0011, 1'b0, 32'd100, 32'd7, 0, lat);
        check("divu_lat", lat, 33);
        check("divu_lo", lo, 14);
        check("divu_hi", hi, 2);
        run_op(4'b1010, 1'b0, 0, 0, 0, lat);
        check("mfhi", result, 2);
        check("mfhi_lat", lat, 1);
        run_op(4'b1011, 1'b0, 0, 0, 0, lat);
        check("mflo", result, 14);

        // signed divides
        run_op(4'b0011, 1'b1, -32'sd7, 32'd2, 0, lat);
        check("divs_lo", lo, 32'hFFFFFFFD);
        check("divs_hi", hi, 32'hFFFFFFFF);
        run_op(4'b0011, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, lat);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 0);
        check("divovf_dbz", div_by_zero, 0);

        // divide by zero
        run_op(4'b0011, 1'b0, 32'd1234, 32'd0, 0, lat);
        check("dbz_lat", lat, 2);
        check("dbz_lo", lo, 32'hFFFFFFFF);
        check("dbz_hi", hi, 32'd1234);
        check("dbz_flag", div_by_zero, 1);
        check("dbz_res", result, 32'hFFFFFFFF);
        run_op(4'b0000, 1'b0, 0, 0, 0, lat);
        check("dbz_clear", div_by_zero, 0);
        check("add_zero", zero, 1);

        // single-cycle ops
        run_op(4'b1000, 1'b0, 32'hF0000000, 32'd4, 0, lat);
        check("srl", result, 32'h0F000000);
        run_op(4'b1000, 1'b1, 32'hF0000000, 32'd4, 0, lat);
        check("sra", result, 32'hFF000000);
        run_op(4'b1001, 1'b1, 32'hFFFFFFFF, 32'd1, 0, lat);
        check("slt_s", result, 1);
        run_op(4'b1001, 1'b0, 32'hFFFFFFFF, 32'd1, 0, lat);
        check("slt_u", result, 0);
        check("slt_u_zero", zero, 1);
        run_op(4'b0001, 1'b0, 32'd3, 32'd5, 0, lat);
        check("sub", result, 32'hFFFFFFFE);
        run_op(4'b0100, 1'b0, 32'hF0F0_1234, 32'hFF00_00FF, 0, lat);
        check("and", result, 32'hF000_0034);
        run_op(4'b0101, 1'b0, 32'hF0F0_1234, 32'h0F00_00FF, 0, lat);
        check("or", result, 32'hFFF0_12FF);
        run_op(4'b0110, 1'b0, 32'h0000_FFFF, 32'd0, 0, lat);
        check("not", result, 32'hFFFF_0000);
        run_op(4'b0111, 1'b0, 32'd1, 32'd31, 0, lat);
        check("sll31", result, 32'h80000000);
        run_op(4'b0111, 1'b0, 32'd5, 32'd32, 0, lat);
        check("sll_wrap", result, 5);
        run_op(4'b1100, 1'b0, 32'd5, 32'd5, 0, lat);
        check("rsv_res", result, 0);
        check("rsv_lat", lat, 1);
        check("rsv_hilo", {hi, lo}, {32'd1234, 32'hFFFFFFFF});

        // back-to-back single-cycle ops
        @(negedge clk);
        alucontrol = 4'b0000; sign = 1'b0; a = 1; b = 2; start = 1'b1;
        @(posedge clk); #1;
        check("b2b_1", {31'd0, done, result}, {31'd0, 1'b1, 32'd3});
        a = 10; b = 20;
        @(posedge clk); #1;
        check("b2b_2", {31'd0, done, result}, {31'd0, 1'b1, 32'd30});
        start = 1'b0;

        // reset in the middle of a divide
        @(negedge clk);
        alucontrol = 4'b0011; sign = 1'b0; a = 100; b = 7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_busy_pre", busy, 1);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hilo", {hi, lo}, 0);
        check("abort_done", done, 0);
        @(negedge clk); reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
